// File: rtl/spi_o_pkg.sv
// Shared constants for both ends of the SPI MISO frame link.
// Also holds the transmitter state encoding and a counter-width helper.
package spi_o_pkg;

  localparam int DATA_W_DEF       = 120;
  localparam int BIT_CYCLES_DEF   = 20;
  localparam int FRAME_CYCLES_DEF = DATA_W_DEF * BIT_CYCLES_DEF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Width of a counter running 0..terminal-1, never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal < 2) ? 1 : $clog2(terminal);
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Per-bit cycle counter. It flags the last cycle of a bit and the cycle before it.
// The SPI frame receiver's sampler uses the same counter.
module spi_bit_timer
  import spi_o_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int CNT_W      = cnt_width(BIT_CYCLES)
) (
  input  logic m_clk,
  input  logic n_reset,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_CYC  = CNT_W'(BIT_CYCLES - 2);

  logic [CNT_W-1:0] cyc_cnt_r;

  // Cycle counter: wraps on the terminal count and is held at zero while cleared.
  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      cyc_cnt_r <= {CNT_W{1'b0}};
    end else if (clear || bit_tick) begin
      cyc_cnt_r <= {CNT_W{1'b0}};
    end else begin
      cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
    end
  end

  assign bit_tick = (cyc_cnt_r == LAST_CYC);
  assign pre_tick = (cyc_cnt_r == PRE_CYC);

endmodule

// File: rtl/spi_miso_frame_tx.sv
// Serializes DATA_W-bit frames onto spi_miso_out, holding each bit for BIT_CYCLES clocks.
// A one-deep holding buffer lets the next frame follow the current one with no gap.
module spi_miso_frame_tx
  import spi_o_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              m_clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              spi_miso_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int               BIT_W    = cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_e         state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s, shift_adv_s;
  logic [DATA_W-1:0] hold_r, hold_s;
  logic              hold_full_r, hold_full_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic              miso_r, miso_s;
  logic              busy_r, ready_r, done_r, done_s;
  logic              accept_s, last_bit_s, timer_clear_s;
  logic              bit_tick_s, pre_tick_s;

  assign accept_s      = load_valid && ready_r;
  assign last_bit_s    = (bit_cnt_r == LAST_BIT);
  assign timer_clear_s = (state_r == ST_IDLE);

  spi_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .m_clk    (m_clk),
    .n_reset  (n_reset),
    .clear    (timer_clear_s),
    .bit_tick (bit_tick_s),
    .pre_tick (pre_tick_s)
  );

  // Next-state logic for the frame FSM, shifter, holding buffer and line value.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    bit_cnt_s   = bit_cnt_r;
    miso_s      = IDLE_LEVEL;
    shift_adv_s = LSB_FIRST ? {1'b0, shift_r[DATA_W-1:1]} : {shift_r[DATA_W-2:0], 1'b0};
    // Registered pulse: raised on the edge that enters the frame's final cycle.
    done_s      = (state_r == ST_SHIFT) && last_bit_s && pre_tick_s;

    case (state_r)
      ST_IDLE: begin
        hold_full_s = 1'b0;
        if (accept_s) begin
          shift_s   = load_data;
          bit_cnt_s = {BIT_W{1'b0}};
          state_s   = ST_SHIFT;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_tick_s && last_bit_s) begin
          // End of frame: chain the next frame straight into the shifter if one is ready.
          bit_cnt_s = {BIT_W{1'b0}};
          if (hold_full_r) begin
            shift_s     = hold_r;
            hold_full_s = 1'b0;
          end else if (accept_s) begin
            shift_s     = load_data;
          end else begin
            state_s     = ST_IDLE;
          end
        end else begin
          if (bit_tick_s) begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            shift_s   = shift_adv_s;
          end else begin
            shift_s   = shift_r;
          end
          if (accept_s) begin
            hold_s      = load_data;
            hold_full_s = 1'b1;
          end else begin
            hold_full_s = hold_full_r;
          end
        end
      end
      default: begin
        state_s     = ST_IDLE;
        hold_full_s = 1'b0;
      end
    endcase

    if (state_s == ST_SHIFT) begin
      miso_s = LSB_FIRST ? shift_s[0] : shift_s[DATA_W-1];
    end else begin
      miso_s = IDLE_LEVEL;
    end
  end

  // State and output registers.
  always_ff @(posedge m_clk) begin
    if (!n_reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= {DATA_W{1'b0}};
      hold_r      <= {DATA_W{1'b0}};
      hold_full_r <= 1'b0;
      bit_cnt_r   <= {BIT_W{1'b0}};
      miso_r      <= IDLE_LEVEL;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      bit_cnt_r   <= bit_cnt_s;
      miso_r      <= miso_s;
      busy_r      <= (state_s == ST_SHIFT);
      ready_r     <= ~hold_full_s;
      done_r      <= done_s;
    end
  end

  assign load_ready   = ready_r;
  assign spi_miso_out = miso_r;
  assign tx_busy      = busy_r;
  assign frame_done   = done_r;

endmodule

// File: doc/spi_miso_frame_tx.md
Name: spi_miso_frame_tx

Overview:
- Serial frame transmitter for the peer end of the SPI frame receiver's MISO link.
- Accepts a parallel DATA_W-bit frame over a valid/ready handshake and serializes it onto spi_miso_out.
- Each bit is held for BIT_CYCLES m_clk cycles, matching the receiver's fixed-rate sampling.
- A one-deep holding buffer allows back-to-back frames with no idle gap.

Parameters:
DATA_W, 120, frame width in bits; must be a multiple of 8.
BIT_CYCLES, 20, m_clk cycles per serial bit; minimum 2.
LSB_FIRST, 1, 1 = bit 0 of each byte sent first, bytes in ascending order; 0 = bit DATA_W-1 sent first.
IDLE_LEVEL, 0, spi_miso_out value when no frame is active.

Ports:
m_clk  in  1  system clock; all logic on the rising edge.
n_reset  in  1  synchronous, active-low reset.
load_data  in  DATA_W  frame to transmit.
load_valid  in  1  load_data is valid.
load_ready  out  1  block can accept a frame this cycle.
spi_miso_out  out  1  serial data line.
tx_busy  out  1  a frame is being shifted.
frame_done  out  1  one-cycle pulse on the last cycle of a frame's last bit.

Behaviour:
- Reset (n_reset=0 at a rising edge), on the next edge:
  - spi_miso_out=IDLE_LEVEL, load_ready=1, tx_busy=0, frame_done=0.
  - Holding buffer empty, counters cleared, state IDLE.
  - Reset mid-frame aborts the frame immediately; no frame_done is generated.
- Transfer: a frame is accepted when load_valid && load_ready at a rising edge.
- State IDLE:
  - spi_miso_out=IDLE_LEVEL, tx_busy=0.
  - On acceptance, load the shift register, set bit_cnt=0, cyc_cnt=0, go to SHIFT.
  - spi_miso_out shows bit 0 from the following cycle (1-cycle latency).
- State SHIFT:
  - tx_busy=1; spi_miso_out holds the current bit for exactly BIT_CYCLES cycles.
  - cyc_cnt counts 0..BIT_CYCLES-1. When cyc_cnt=BIT_CYCLES-1: cyc_cnt wraps to 0, bit_cnt increments, and the shift register advances one bit (toward the LSB when LSB_FIRST=1).
  - Last cycle of a frame is bit_cnt=DATA_W-1 with cyc_cnt=BIT_CYCLES-1:
    - frame_done=1 for that cycle.
    - If the holding buffer is full, or a frame is accepted in this same cycle, that frame goes straight to the shift register. bit_cnt=0 and SHIFT continues with no gap cycle; the buffer is left empty.
    - Otherwise go to IDLE; the line returns to IDLE_LEVEL on the next cycle.
- Holding buffer:
  - load_ready = !hold_full.
  - In SHIFT, an accepted frame goes to the holding buffer, except on the last cycle as described above.
  - In IDLE the buffer is always empty.
  - load_ready deasserts the cycle after a fill and reasserts the cycle after the buffer is drained.
- load_valid while load_ready=0 is ignored; the source holds it.
- frame_done is registered; it is never asserted in IDLE and never for two consecutive cycles.
- Widths:
  - bit_cnt is clog2(DATA_W) bits and cyc_cnt is clog2(BIT_CYCLES) bits; neither is allowed to pass its terminal value.
  - Frame duration is DATA_W*BIT_CYCLES cycles (2400 at defaults).

Decomposition:
- Shared package/header spi_o_pkg:
  - DATA_W and BIT_CYCLES defaults, and the IDLE/SHIFT state encoding.
  - Constants shared with the SPI frame receiver, so both ends agree on frame width and bit rate.
- Sub-module spi_bit_timer:
  - Cycle counter with a clear input.
  - Outputs a bit_tick on cyc_cnt=BIT_CYCLES-1.
  - Reusable by the receiver's sampler.

Test Plan:
- Reset/idle: hold n_reset=0 for 25 cycles, then release with load_valid=0. Required: spi_miso_out=0, load_ready=1, tx_busy=0, frame_done=0 for 100 cycles.
- Single frame: load byte0=0x01, byte1=0x02, rest 0 in IDLE.
  - Line pattern from the next cycle: 1,0,0,0,0,0,0,0 then 0,1,0,0,0,0,0,0, each bit held 20 cycles (2000 ns at a 100 ns clock).
  - frame_done on cycle 2400; tx_busy falls and the line returns to 0 on cycle 2401.
- Back-to-back: load frame A, then frame B at cycle 100. Required: load_ready=0 from cycle 101 until B moves to the shifter. B's bit 0 starts the cycle after A's frame_done with zero gap; frame_done fires twice, 2400 cycles apart.
- Last-cycle load: with the buffer empty, assert load_valid exactly on A's frame_done cycle. Required: accepted that cycle and the next frame starts immediately with no IDLE cycle.
- Reset mid-frame: drop n_reset at bit 57, cycle 7. Required: the next edge gives line=0, tx_busy=0, load_ready=1, no frame_done. A new frame afterward transmits correctly from bit 0.
- Loopback: feed spi_miso_out into the SPI frame receiver and send 0xFF..FF then 0xA5 repeated. Required: receiver data_out equals each loaded frame bit-exact.
